mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles a granted transaction may run without m_ack before it is aborted.
REQ-002 Parameter DATA_FIRST, default 1: grants data when both ports request and the round-robin flag is in its reset value.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 i_stb  in  1 / i_addr  in  32  instruction fetch request and address, held until i_ack or i_err.
REQ-006 i_ack  out  1 / i_err  out  1 / i_data  out  32  fetch completion pulse, abort pulse and read data.
REQ-007 d_stb  in  1 / d_we  in  1 / d_addr  in  32 / d_wr_data  in  32 / d_sel  in  4  data request, held until d_ack or d_err.
REQ-008 d_ack  out  1 / d_err  out  1 / d_rd_data  out  32  data completion pulse, abort pulse and read data.
REQ-009 m_cyc, m_stb, m_we  out  1 / m_addr, m_wr_data  out  32 / m_sel  out  4  shared pipelined Wishbone master.
REQ-010 m_ack, m_stall  in  1 / m_rd_data  in  32  shared Wishbone slave response.

Function
REQ-011 FSM states: IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT; at most one bus transaction is outstanding.
REQ-012 IDLE with exactly one request asserted -> matching *_REQ on the next edge.
REQ-013 IDLE with both requests asserted -> grants the port not served last (rr flag); rr flag reset value selects data when DATA_FIRST=1.
REQ-014 m_cyc, m_stb, m_we, m_addr, m_wr_data, m_sel are registered; first m_stb cycle is the cycle after the request is sampled in IDLE (1-cycle grant latency).
REQ-015 *_REQ: m_cyc=1, m_stb=1; m_stb stays high while m_stall=1; m_stall=0 -> *_WAIT with m_stb=0 next cycle.
REQ-016 *_WAIT: m_cyc=1, m_stb=0; m_ack=1 -> IDLE with m_cyc=0 next cycle.
REQ-017 m_ack=1 in *_REQ with m_stall=0 in the same cycle completes the transaction directly -> IDLE.
REQ-018 i_ack/d_ack are combinational: equal to m_ack while the respective port is granted and in REQ/WAIT, otherwise 0.
REQ-019 i_data and d_rd_data follow m_rd_data; valid only in the corresponding ack cycle.
REQ-020 For instruction grants, m_we=0 and m_sel=4'b1111.
REQ-021 Address, write data, write enable and select are captured on grant and held constant for the whole transaction.
REQ-022 The rr flag updates on grant to the granted port.
REQ-023 Timeout counter clears on grant and increments each REQ/WAIT cycle without m_ack; on reaching TIMEOUT: m_cyc=m_stb=0 next cycle, one-cycle *_err pulse to the granted port, -> IDLE.
REQ-024 m_ack in the cycle the counter reaches TIMEOUT wins: normal completion, no err.
REQ-025 m_ack in IDLE is ignored; no ack or err is forwarded to either port.
REQ-026 Requester deasserting stb mid-transaction does not abort the transaction; the bus cycle completes and ack is still forwarded.
REQ-027 A new grant from IDLE is issued no earlier than the cycle after m_cyc falls; m_cyc is low for at least one cycle between transactions.

Reset
REQ-028 rst=0 immediately forces IDLE; m_cyc, m_stb, m_we, i_err, d_err = 0; m_addr, m_wr_data = 0; m_sel = 0; rr flag and counter = 0.
REQ-029 Reset asserted mid-transaction drops m_cyc/m_stb asynchronously; no ack or err is issued for the aborted transaction.

Structure
REQ-030 Package mem_arb_pkg holds the FSM state enum, the grant enum (GRANT_I, GRANT_D) and the Wishbone width constants (address 32, data 32, select 4).
REQ-031 One sub-module, bus_timer (clear, enable, TIMEOUT parameter, expired output), implements the timeout counter; all remaining logic resides in mem_arbiter.

Verification
REQ-032 i_stb=1, i_addr=0x100, slave acks 2 cycles after stb acceptance -> m_stb one cycle, m_addr=0x100, m_sel=F, i_ack one pulse carrying i_data=m_rd_data.
REQ-033 i_stb and d_stb rise together (d_we=1, d_addr=0x2000, d_sel=3), DATA_FIRST=1 -> data granted first, fetch granted after m_cyc drops; repeat -> order alternates.
REQ-034 d_stb with m_stall=1 for 3 cycles -> m_stb high 4 cycles, address/data stable, single d_ack.
REQ-035 TIMEOUT=8, slave never acks -> m_cyc drops after 8 cycles, one d_err pulse, no d_ack, next request granted.
REQ-036 rst=0 during D_WAIT -> m_cyc=0 without a clock edge, no ack/err; after release the pending i_stb is granted normally.
REQ-037 m_ack coincident with stall release in *_REQ, and m_ack on the timeout cycle -> both complete with ack and no err.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and Wishbone widths for the instruction/data arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;
    localparam int c_SEL_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_REQ  = 3'd1,
        ST_I_WAIT = 3'd2,
        ST_D_REQ  = 3'd3,
        ST_D_WAIT = 3'd4
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : bus_timer
// Brief    : Counts bus cycles without an ack; flags the cycle that hits TIMEOUT.
// Revision : 1.0
// ============================================================================
module bus_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             c_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT - 1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + c_W'(1);
        end
    end

    // High in the cycle whose increment would reach TIMEOUT
    assign expired = enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one pipelined Wishbone master between
//            an instruction-fetch port and a data port, with bus timeout.
// Revision : 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT    = 255,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_stb,
    input  logic [c_ADDR_W-1:0] i_addr,
    output logic                i_ack,
    output logic                i_err,
    output logic [c_DATA_W-1:0] i_data,
    input  logic                d_stb,
    input  logic                d_we,
    input  logic [c_ADDR_W-1:0] d_addr,
    input  logic [c_DATA_W-1:0] d_wr_data,
    input  logic [c_SEL_W-1:0]  d_sel,
    output logic                d_ack,
    output logic                d_err,
    output logic [c_DATA_W-1:0] d_rd_data,
    output logic                m_cyc,
    output logic                m_stb,
    output logic                m_we,
    output logic [c_ADDR_W-1:0] m_addr,
    output logic [c_DATA_W-1:0] m_wr_data,
    output logic [c_SEL_W-1:0]  m_sel,
    input  logic                m_ack,
    input  logic                m_stall,
    input  logic [c_DATA_W-1:0] m_rd_data
);

    // With DATA_FIRST=0 the stored flag is inverted so reset still alternates fairly
    localparam logic c_RR_POL = (DATA_FIRST == 1'b0);

    arb_state_t r_state;
    logic       r_rr;

    logic   w_i_req;
    logic   w_d_req;
    logic   w_start;
    grant_t w_grant;
    logic   w_i_own;
    logic   w_d_own;
    logic   w_expired;
    logic   w_done;

    // A port that is seeing its err pulse is about to drop stb; do not re-grant it
    assign w_i_req = i_stb && !i_err;
    assign w_d_req = d_stb && !d_err;
    assign w_start = (r_state == ST_IDLE) && (w_i_req || w_d_req);
    assign w_grant = (w_d_req && (!w_i_req || (r_rr == c_RR_POL))) ? GRANT_D : GRANT_I;

    assign w_i_own = (r_state == ST_I_REQ) || (r_state == ST_I_WAIT);
    assign w_d_own = (r_state == ST_D_REQ) || (r_state == ST_D_WAIT);
    assign w_done  = m_ack || w_expired;

    assign i_ack     = w_i_own && m_ack;
    assign d_ack     = w_d_own && m_ack;
    assign i_data    = m_rd_data;
    assign d_rd_data = m_rd_data;

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_start),
        .enable  ((w_i_own || w_d_own) && !m_ack),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_rr      <= 1'b0;
            m_cyc     <= 1'b0;
            m_stb     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wr_data <= '0;
            m_sel     <= '0;
            i_err     <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            i_err <= 1'b0;
            d_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        m_cyc <= 1'b1;
                        m_stb <= 1'b1;
                        r_rr  <= (w_grant == GRANT_D) ^ c_RR_POL;
                        if (w_grant == GRANT_D) begin
                            r_state   <= ST_D_REQ;
                            m_we      <= d_we;
                            m_addr    <= d_addr;
                            m_wr_data <= d_wr_data;
                            m_sel     <= d_sel;
                        end else begin
                            r_state   <= ST_I_REQ;
                            m_we      <= 1'b0;
                            m_addr    <= i_addr;
                            m_wr_data <= '0;
                            m_sel     <= '1;
                        end
                    end
                end
                ST_I_REQ, ST_D_REQ, ST_I_WAIT, ST_D_WAIT: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                        m_cyc   <= 1'b0;
                        m_stb   <= 1'b0;
                        if (!m_ack) begin
                            i_err <= w_i_own;
                            d_err <= w_d_own;
                        end
                    end else if ((r_state == ST_I_REQ) && !m_stall) begin
                        r_state <= ST_I_WAIT;
                        m_stb   <= 1'b0;
                    end else if ((r_state == ST_D_REQ) && !m_stall) begin
                        r_state <= ST_D_WAIT;
                        m_stb   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    m_cyc   <= 1'b0;
                    m_stb   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Randomised scoreboard bench for mem_arbiter with a behavioural slave.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_stb, i_ack, i_err;
    logic [31:0] i_addr, i_data;
    logic        d_stb, d_we, d_ack, d_err;
    logic [31:0] d_addr, d_wr_data, d_rd_data;
    logic [3:0]  d_sel;
    logic        m_cyc, m_stb, m_we, m_ack, m_stall;
    logic [31:0] m_addr, m_wr_data, m_rd_data;
    logic [3:0]  m_sel;

    always #5 clk = ~clk;

    mem_arbiter #(
        .TIMEOUT    (TO),
        .DATA_FIRST (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_stb     (i_stb),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_err     (i_err),
        .i_data    (i_data),
        .d_stb     (d_stb),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wr_data (d_wr_data),
        .d_sel     (d_sel),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .d_rd_data (d_rd_data),
        .m_cyc     (m_cyc),
        .m_stb     (m_stb),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wr_data (m_wr_data),
        .m_sel     (m_sel),
        .m_ack     (m_ack),
        .m_stall   (m_stall),
        .m_rd_data (m_rd_data)
    );

    // Slave behaviour per address: kind 0 acks L cycles after accepting, kind 1 never acks
    typedef struct { int kind; int s; int l; } beh_t;
    typedef struct { logic err; logic [31:0] data; } resp_t;

    beh_t        beh [logic [31:0]];
    resp_t       exp_i[$];
    resp_t       exp_d[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_i_addr = '0, cur_d_addr = '0, cur_d_wdata = '0;
    logic        cur_d_we = 1'b0;
    logic [3:0]  cur_d_sel = '0;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    int   sl_n = 0;
    beh_t sl_b;
    initial begin
        m_ack = 1'b0; m_stall = 1'b0; m_rd_data = '0;
        sl_b = '{0, 0, 0};
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                sl_n = 0; m_ack = 1'b0; m_stall = 1'b0;
            end else if (m_cyc) begin
                if (sl_n == 0) sl_b = beh.exists(m_addr) ? beh[m_addr] : '{1, 0, 0};
                sl_n++;
                m_stall   = (sl_n <= sl_b.s);
                m_ack     = (sl_b.kind == 0) && (sl_n == sl_b.s + 1 + sl_b.l);
                m_rd_data = m_ack ? rd_val(m_addr) : $urandom;
            end else begin
                // idle bus: random noise on the slave lines must be ignored
                sl_n      = 0;
                m_stall   = 1'($urandom_range(0, 1));
                m_ack     = ($urandom_range(0, 3) == 0);
                m_rd_data = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic  p_cyc = 1'b0, p_pi = 1'b0, p_pd = 1'b0, last_g = 1'b0, exp_port;
    int    len = 0;
    beh_t  gb;
    logic [31:0] gaddr = '0;
    resp_t mr;
    initial begin
        gb = '{0, 0, 0};
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_i.delete(); exp_d.delete();
                p_cyc = 1'b0; p_pi = 1'b0; p_pd = 1'b0; last_g = 1'b0; len = 0;
            end else begin
                if (i_ack || i_err) begin
                    check("i_resp_expected", 32'(exp_i.size() > 0), 32'd1);
                    if (exp_i.size() > 0) begin
                        mr = exp_i.pop_front();
                        check("i_err_kind", 32'(i_err), 32'(mr.err));
                        check("i_ack_kind", 32'(i_ack), 32'(!mr.err));
                        if (i_ack) check("i_data", i_data, mr.data);
                    end
                end
                if (d_ack || d_err) begin
                    check("d_resp_expected", 32'(exp_d.size() > 0), 32'd1);
                    if (exp_d.size() > 0) begin
                        mr = exp_d.pop_front();
                        check("d_err_kind", 32'(d_err), 32'(mr.err));
                        check("d_ack_kind", 32'(d_ack), 32'(!mr.err));
                        if (d_ack) check("d_rd_data", d_rd_data, mr.data);
                    end
                end
                if (i_ack || d_ack) check("ack_inside_cycle", 32'(m_cyc), 32'd1);
                if (!p_cyc && (p_pi || p_pd)) check("grant_latency", 32'(m_cyc), 32'd1);
                if (m_cyc && !p_cyc) begin
                    check("grant_had_request", 32'(p_pi || p_pd), 32'd1);
                    exp_port = (p_pi && p_pd) ? !last_g : p_pd;
                    last_g   = exp_port;
                    gaddr    = exp_port ? cur_d_addr : cur_i_addr;
                    check("grant_addr", m_addr, gaddr);
                    check("grant_we", 32'(m_we), exp_port ? 32'(cur_d_we) : 32'd0);
                    check("grant_sel", 32'(m_sel), exp_port ? 32'(cur_d_sel) : 32'hF);
                    if (exp_port) check("grant_wdata", m_wr_data, cur_d_wdata);
                    gb  = beh.exists(gaddr) ? beh[gaddr] : '{1, 0, 0};
                    len = 0;
                end
                if (m_cyc) begin
                    len++;
                    check("addr_stable", m_addr, gaddr);
                    check("stb_shape", 32'(m_stb), 32'(len <= gb.s + 1));
                end
                if (!m_cyc && p_cyc) begin
                    check("cyc_length", len, (gb.kind == 0) ? gb.s + 1 + gb.l : TO);
                    if (gb.kind == 1) check("err_on_fall", 32'(last_g ? d_err : i_err), 32'd1);
                end
                p_cyc = m_cyc;
                p_pi  = i_stb && !i_err;
                p_pd  = d_stb && !d_err;
            end
        end
    end

    // ---------------- requesters ----------------
    task automatic requester(input logic port, input int n);
        logic [31:0] addr;
        beh_t        b;
        int          r;
        logic        done;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            addr = (port ? 32'h2000_0000 : 32'h1000_0000) + 32'(k * 16);
            r = $urandom_range(0, 9);
            if (r < 6)      b = '{0, $urandom_range(0, 3), $urandom_range(0, 3)};
            else if (r < 8) begin b.kind = 0; b.s = $urandom_range(0, 7); b.l = 7 - b.s; end
            else            b = '{1, (r == 8) ? 0 : 12, 0};
            beh[addr] = b;
            if (port) begin
                cur_d_addr = addr; cur_d_we = 1'($urandom); cur_d_sel = 4'($urandom);
                cur_d_wdata = $urandom;
                d_addr = addr; d_we = cur_d_we; d_sel = cur_d_sel; d_wr_data = cur_d_wdata;
                exp_d.push_back('{logic'(b.kind == 1), rd_val(addr)});
                d_stb = 1'b1;
            end else begin
                cur_i_addr = addr; i_addr = addr;
                exp_i.push_back('{logic'(b.kind == 1), rd_val(addr)});
                i_stb = 1'b1;
            end
            done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                @(negedge clk);
                if (port ? (d_ack || d_err) : (i_ack || i_err)) done = 1'b1;
                else if (m_cyc && m_addr == addr && $urandom_range(0, 5) == 0) begin
                    // withdraw after grant and scramble inputs: bus cycle must still finish
                    if (port) begin d_stb = 1'b0; d_addr = $urandom; d_wr_data = $urandom; end
                    else      begin i_stb = 1'b0; i_addr = $urandom; end
                end
            end
            if (!done) begin
                checks++; errors++;
                $display("FAIL req_timeout: port %0d got no response, expected one", port);
            end
            @(posedge clk); #1;
            if (port) d_stb = 1'b0; else i_stb = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] a_d, a_i;
    logic        ok;
    initial begin
        i_stb = 1'b0; i_addr = '0;
        d_stb = 1'b0; d_we = 1'b0; d_addr = '0; d_wr_data = '0; d_sel = '0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("rst_m_cyc", 32'(m_cyc), 0);
        check("rst_m_stb", 32'(m_stb), 0);
        check("rst_m_we", 32'(m_we), 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wr_data", m_wr_data, 0);
        check("rst_m_sel", 32'(m_sel), 0);
        check("rst_errs", 32'({i_err, d_err}), 0);
        check("rst_acks", 32'({i_ack, d_ack}), 0);
        rst = 1'b1;

        fork
            requester(1'b0, 40);
            requester(1'b1, 40);
        join
        repeat (3) @(posedge clk);

        // reset during a data wait phase with a fetch queued behind it
        @(posedge clk); #1;
        a_d = 32'h3000_0000; beh[a_d] = '{1, 0, 0};
        cur_d_addr = a_d; cur_d_we = 1'b1; cur_d_sel = 4'h3; cur_d_wdata = 32'hDEAD_BEEF;
        d_addr = a_d; d_we = 1'b1; d_sel = 4'h3; d_wr_data = 32'hDEAD_BEEF; d_stb = 1'b1;
        @(posedge clk); #1;
        a_i = 32'h0000_0100; beh[a_i] = '{0, 0, 2};
        cur_i_addr = a_i; i_addr = a_i; i_stb = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (m_cyc && !m_stb && m_addr == a_d) ok = 1'b1;
        end
        check("reach_d_wait", 32'(ok), 1);
        @(posedge clk); #3;
        rst = 1'b0; #1;
        check("async_rst_cyc", 32'({m_cyc, m_stb}), 0);
        check("async_rst_resp", 32'({d_ack, d_err, i_ack, i_err}), 0);
        d_stb = 1'b0;
        @(posedge clk); #1;
        check("rst_no_err", 32'({d_err, i_err}), 0);
        exp_i.push_back('{1'b0, rd_val(a_i)});
        #2 rst = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge clk);
            if (i_ack || i_err) ok = 1'b1;
        end
        check("post_rst_fetch_resp", 32'(ok), 1);
        @(posedge clk); #1;
        i_stb = 1'b0;
        repeat (4) @(posedge clk);
        check("queues_drained", 32'(exp_i.size() + exp_d.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
